// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the descriptor scheduler
package dma_pkg;

    typedef struct packed {
        logic [2:0] id;
        logic       last;
    } dsc_tag_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam int unsigned DEF_MAX_DSC_LEN = 4096;

    function automatic logic [63:0] dsc_mask(input int unsigned max_len);
        return 64'(max_len - 1);
    endfunction

endpackage

// File: rtl/dma_desc_scheduler_if.sv
// dma_desc_scheduler_if: XDMA descriptor bypass channel plus completion pulse
interface dma_desc_scheduler_if;

    logic        dsc_byp_ready;
    logic        dsc_byp_load;
    logic [63:0] dsc_byp_addr;
    logic [31:0] dsc_byp_len;
    logic        dsc_done;

    modport master (
        input  dsc_byp_ready, dsc_done,
        output dsc_byp_load, dsc_byp_addr, dsc_byp_len
    );

    modport slave (
        output dsc_byp_ready, dsc_done,
        input  dsc_byp_load, dsc_byp_addr, dsc_byp_len
    );

endinterface

// File: rtl/dma_tag_fifo.sv
// dma_tag_fifo: first-word-fall-through FIFO of issued descriptor tags, in issue order
module dma_tag_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     pcie_clk,
    input  logic     pcie_rst,
    input  logic     push,
    input  logic     pop,
    input  dsc_tag_t din,
    output dsc_tag_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    dsc_tag_t    mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        do_push, do_pop;

    // a pop in the same cycle frees a slot, so push on full is legal alongside it
    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        head    = mem_q[rd_q[AW-1:0]];
    end

    // storage needs no reset: occupancy is defined by the pointers alone
    always_ff @(posedge pcie_clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

    // pointer registers
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

endmodule

// File: rtl/dma_desc_scheduler.sv
// dma_desc_scheduler: round-robin sharing of one XDMA descriptor bypass channel
module dma_desc_scheduler
    import dma_pkg::*;
#(
    parameter int          NUM_REQ         = 4,
    parameter int unsigned MAX_DSC_LEN     = DEF_MAX_DSC_LEN,
    parameter int          MAX_OUTSTANDING = 8
) (
    input  logic                             pcie_clk,
    input  logic                             pcie_rst,
    input  logic [NUM_REQ-1:0]               cmd_valid,
    output logic [NUM_REQ-1:0]               cmd_ready,
    input  logic [NUM_REQ*64-1:0]            cmd_addr,
    input  logic [NUM_REQ*32-1:0]            cmd_len,
    output logic [NUM_REQ-1:0]               cmd_done,
    dma_desc_scheduler_if.master             byp,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             err_zero_len,
    output logic                             err_spurious_done
);

    localparam int          OW       = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [63:0] DSC_MASK = dsc_mask(MAX_DSC_LEN);

    state_t             state_q, state_d;
    logic [2:0]         rr_q, rr_d, id_q, id_d, gid;
    logic [63:0]        addr_q, addr_d;
    logic [31:0]        rem_q, rem_d, blen_q, blen_d;
    logic [OW-1:0]      out_q, out_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               load_q, load_d, errz_q, errz_d, errs_q, errs_d;
    logic               found, accept, last, full, empty;
    logic [32:0]        room;
    dsc_tag_t           head, tag_in;
    int                 idx;

    // round-robin search starting at the requester after the previous grant
    always_comb begin
        found = 1'b0;
        gid   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!found && cmd_valid[idx]) begin
                found = 1'b1;
                gid   = 3'(idx);
            end
        end
        cmd_ready = (state_q == IDLE && found && !pcie_rst) ? NUM_REQ'(1) << gid : '0;
    end

    // command sequencing, boundary-aligned splitting and completion tracking
    always_comb begin
        accept  = load_q && byp.dsc_byp_ready;
        last    = rem_q == blen_q;
        tag_in  = '{id: id_q, last: last};
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        errz_d  = errz_q;
        if (state_q == IDLE && found) begin
            rr_d    = (int'(gid) == NUM_REQ - 1) ? 3'd0 : gid + 3'd1;
            id_d    = gid;
            addr_d  = cmd_addr[64*gid +: 64];
            rem_d   = cmd_len[32*gid +: 32];
            errz_d  = errz_q || rem_d == '0;
            state_d = rem_d == '0 ? IDLE : ISSUE;
        end else if (state_q == ISSUE && accept) begin
            addr_d  = addr_q + 64'(blen_q);
            rem_d   = rem_q - blen_q;
            state_d = last ? IDLE : ISSUE;
        end
        room   = 33'(MAX_DSC_LEN) - 33'(addr_d & DSC_MASK);
        blen_d = {1'b0, rem_d} < room ? rem_d : room[31:0];
        out_d  = out_q + OW'(accept) - OW'(byp.dsc_done && !empty);
        load_d = state_d == ISSUE && out_d < OW'(MAX_OUTSTANDING) && (!full || byp.dsc_done);
        errs_d = errs_q || (byp.dsc_done && empty);
        done_d = (byp.dsc_done && !empty && head.last) ? NUM_REQ'(1) << head.id : '0;
    end

    // state and registered outputs
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            blen_q  <= '0;
            out_q   <= '0;
            done_q  <= '0;
            load_q  <= 1'b0;
            errz_q  <= 1'b0;
            errs_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            blen_q  <= blen_d;
            out_q   <= out_d;
            done_q  <= done_d;
            load_q  <= load_d;
            errz_q  <= errz_d;
            errs_q  <= errs_d;
        end
    end

    dma_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
        .pcie_clk (pcie_clk),
        .pcie_rst (pcie_rst),
        .push     (accept),
        .pop      (byp.dsc_done),
        .din      (tag_in),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    assign byp.dsc_byp_load = load_q;
    assign byp.dsc_byp_addr = addr_q;
    assign byp.dsc_byp_len  = blen_q;
    assign cmd_done          = done_q;
    assign outstanding       = out_q;
    assign err_zero_len      = errz_q;
    assign err_spurious_done = errs_q;

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// tb_dma_desc_scheduler: randomized bench against a transaction-level reference model
module tb_dma_desc_scheduler;

    localparam int N  = 4;
    localparam int ML = 4096;
    localparam int MO = 8;

    typedef struct {
        int          r;
        logic [63:0] a;
        logic [31:0] l;
    } cmd_t;

    typedef struct {
        logic [63:0] a;
        logic [31:0] l;
        int          id;
        bit          last;
    } dsc_t;

    logic            pcie_clk = 1'b0;
    logic            pcie_rst = 1'b1;
    logic [N-1:0]    cmd_valid = '0, cmd_ready, cmd_done;
    logic [N*64-1:0] cmd_addr = '0;
    logic [N*32-1:0] cmd_len = '0;
    logic [3:0]      outstanding;
    logic            err_zero_len, err_spurious_done;

    dma_desc_scheduler_if byp();

    dma_desc_scheduler #(.NUM_REQ(N), .MAX_DSC_LEN(ML), .MAX_OUTSTANDING(MO)) dut (
        .pcie_clk          (pcie_clk),
        .pcie_rst          (pcie_rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .cmd_done          (cmd_done),
        .byp               (byp),
        .outstanding       (outstanding),
        .err_zero_len      (err_zero_len),
        .err_spurious_done (err_spurious_done)
    );

    always #5 pcie_clk = ~pcie_clk;

    int total = 0;
    int bad   = 0;

    cmd_t         pend[$];
    dsc_t         exp_dsc[$];
    dsc_t         fly[$];
    int           ptr = 0;
    bit           m_errz = 0, m_errs = 0, hold = 0, after_rst = 0;
    logic [N-1:0] m_done = '0;
    logic [63:0]  h_a;
    logic [31:0]  h_l;
    int           ready_pct = 100, done_pct = 0;
    bit           spur = 0, one_done = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_cmd(input int r, input logic [63:0] a, input logic [31:0] l);
        cmd_t c;
        c.r = r;
        c.a = a;
        c.l = l;
        pend.push_back(c);
    endtask

    // expected descriptors: never cross a ML-byte boundary
    task automatic split(input logic [63:0] a, input logic [31:0] l, input int id);
        longint unsigned rem, room, c;
        logic [63:0] cur;
        dsc_t d;
        rem = 64'(l);
        cur = a;
        while (rem > 0) begin
            room = ML - (cur % ML);
            c = rem < room ? rem : room;
            d.a = cur;
            d.l = 32'(c);
            d.id = id;
            d.last = rem == c;
            exp_dsc.push_back(d);
            cur += c;
            rem -= c;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] exp_rdy, nxt_done;
        int g, idx;
        dsc_t d, e;
        cmd_t c;
        @(negedge pcie_clk);
        cmd_valid = '0;
        cmd_addr  = '0;
        cmd_len   = '0;
        foreach (pend[j]) begin
            if (!cmd_valid[pend[j].r]) begin
                cmd_valid[pend[j].r] = 1'b1;
                cmd_addr[64*pend[j].r +: 64] = pend[j].a;
                cmd_len[32*pend[j].r +: 32] = pend[j].l;
            end
        end
        byp.dsc_byp_ready = $urandom_range(99) < ready_pct;
        byp.dsc_done = !pcie_rst && (spur || (fly.size() > 0 &&
                       (one_done || $urandom_range(99) < done_pct)));
        spur = 0;
        one_done = 0;
        #1;
        if (!pcie_rst) begin
            check("cmd_done", 64'(cmd_done), 64'(m_done));
            check("outstanding", 64'(outstanding), 64'(fly.size()));
            check("load", 64'(byp.dsc_byp_load), 64'(exp_dsc.size() > 0 && fly.size() < MO));
            check("err_zero_len", 64'(err_zero_len), 64'(m_errz));
            check("err_spurious", 64'(err_spurious_done), 64'(m_errs));
            if (hold) begin
                check("hold_addr", byp.dsc_byp_addr, h_a);
                check("hold_len", 64'(byp.dsc_byp_len), 64'(h_l));
            end
            if (after_rst) begin
                check("rst_addr", byp.dsc_byp_addr, 64'd0);
                check("rst_len", 64'(byp.dsc_byp_len), 64'd0);
            end
        end
        exp_rdy = '0;
        g = -1;
        if (exp_dsc.size() == 0 && !pcie_rst)
            for (int k = 0; k < N; k++)
                if (g < 0 && cmd_valid[(ptr + k) % N]) g = (ptr + k) % N;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("cmd_ready", 64'(cmd_ready), 64'(exp_rdy));
        if (pcie_rst) begin
            exp_dsc.delete();
            fly.delete();
            ptr = 0;
            m_errz = 0;
            m_errs = 0;
            m_done = '0;
            hold = 0;
            after_rst = 1;
        end else begin
            after_rst = 0;
            nxt_done = '0;
            if (byp.dsc_done) begin
                if (fly.size() == 0) m_errs = 1;
                else begin
                    d = fly.pop_front();
                    if (d.last) nxt_done[d.id] = 1'b1;
                end
            end
            if (byp.dsc_byp_load && byp.dsc_byp_ready) begin
                check("accept_expected", 64'(exp_dsc.size() > 0), 64'd1);
                if (exp_dsc.size() > 0) begin
                    e = exp_dsc.pop_front();
                    check("dsc_addr", byp.dsc_byp_addr, e.a);
                    check("dsc_len", 64'(byp.dsc_byp_len), 64'(e.l));
                    fly.push_back(e);
                end
            end
            if (g >= 0) begin
                idx = 0;
                for (int j = 0; j < pend.size(); j++)
                    if (pend[j].r == g) begin
                        idx = j;
                        break;
                    end
                c = pend[idx];
                pend.delete(idx);
                ptr = (g + 1) % N;
                if (c.l == 0) m_errz = 1;
                else split(c.a, c.l, g);
            end
            m_done = nxt_done;
            hold = byp.dsc_byp_load && !byp.dsc_byp_ready;
            h_a = byp.dsc_byp_addr;
            h_l = byp.dsc_byp_len;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int guard;
        byp.dsc_byp_ready = 1'b0;
        byp.dsc_done = 1'b0;
        run(3);
        pcie_rst = 1'b0;
        // single aligned 4 KiB descriptor, then its completion
        add_cmd(1, 64'h1000, 32'd4096);
        run(4);
        done_pct = 100;
        run(4);
        // unaligned command spanning four descriptors
        done_pct = 0;
        add_cmd(0, 64'h0F00, 32'h2200);
        run(8);
        done_pct = 100;
        run(8);
        // all requesters contending
        done_pct = 50;
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < N; r++) add_cmd(r, 64'(r * 32'h10000 + k * 64), 32'd64);
        run(60);
        // outstanding limit with completions withheld
        done_pct = 100;
        run(20);
        done_pct = 0;
        for (int k = 0; k < 10; k++) add_cmd(2, 64'(k * 32'h1000), 32'd100);
        run(30);
        one_done = 1;
        run(4);
        ready_pct = 0;
        one_done = 1;
        run(2);
        ready_pct = 100;
        one_done = 1;
        run(3);
        done_pct = 100;
        run(30);
        // backpressure mid-command, zero length, spurious completion
        done_pct = 50;
        add_cmd(3, 64'h5000, 32'h3000);
        run(2);
        ready_pct = 0;
        run(5);
        ready_pct = 100;
        run(10);
        add_cmd(1, 64'h100, 32'd0);
        run(4);
        done_pct = 100;
        run(20);
        spur = 1;
        run(3);
        // randomized traffic
        ready_pct = 70;
        done_pct = 40;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0)
                add_cmd(int'($urandom_range(N - 1)), {16'h0, 16'($urandom), $urandom},
                        $urandom_range(19) == 0 ? 32'd0 : 32'($urandom_range(12000, 1)));
            cycle();
        end
        ready_pct = 100;
        done_pct = 100;
        guard = 0;
        while ((pend.size() > 0 || exp_dsc.size() > 0 || fly.size() > 0) && guard < 2000) begin
            cycle();
            guard++;
        end
        check("drain_random", 64'(pend.size() + exp_dsc.size() + fly.size()), 64'd0);
        run(3);
        // reset while issuing with descriptors in flight
        done_pct = 0;
        add_cmd(0, 64'h0, 32'h8000);
        guard = 0;
        while (fly.size() < 3 && guard < 50) begin
            cycle();
            guard++;
        end
        check("inflight_before_rst", 64'(fly.size()), 64'd3);
        pcie_rst = 1'b1;
        run(1);
        pcie_rst = 1'b0;
        for (int r = N - 1; r >= 0; r--) add_cmd(r, 64'(r * 32'h100), 32'd64);
        run(3);
        done_pct = 100;
        run(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
